// File: rtl/game_status.sv
// rtl/game_status.sv - game state FSM with two-stage frame collision/score pipeline
`timescale 1ns/1ps

module game_status #(
    parameter int V_TOT       = 525,
    parameter int GROUND_POS  = 435,
    parameter int SKY_POS     = 0,
    parameter int B_WIDTH     = 16,
    parameter int BIRD_X      = 100,
    parameter int PIPE_W      = 40,
    parameter int GAP_H       = 120,
    parameter int DEAD_FRAMES = 120,
    parameter int SCORE_W     = 8,
    localparam int PW         = $clog2(V_TOT)
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iFrameTick,
    input  logic               iBtnStart,
    input  logic [PW-1:0]      iBirdPos,
    input  logic [PW-1:0]      iPipeX,
    input  logic [PW-1:0]      iGapTop,
    output logic               oBirdMove,
    output logic               oBirdDead,
    output logic [SCORE_W-1:0] oScore,
    output logic [1:0]         oState
);

    localparam int EW = PW + 1;
    localparam int CW = $clog2(DEAD_FRAMES + 1);

    localparam logic [EW-1:0]      C_SKY      = EW'(SKY_POS);
    localparam logic [EW-1:0]      C_GND      = EW'(GROUND_POS);
    localparam logic [EW-1:0]      C_BIRD_L   = EW'(BIRD_X);
    localparam logic [EW-1:0]      C_BIRD_R   = EW'(BIRD_X + B_WIDTH - 1);
    localparam logic [EW-1:0]      C_BW_M1    = EW'(B_WIDTH - 1);
    localparam logic [EW-1:0]      C_PW_M1    = EW'(PIPE_W - 1);
    localparam logic [EW-1:0]      C_GAP_M1   = EW'(GAP_H - 1);
    localparam logic [CW-1:0]      C_DEAD_MAX = CW'(DEAD_FRAMES);
    localparam logic [SCORE_W-1:0] C_SCORE_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DEAD = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_btn_prev;
    logic               r_tick_d;
    logic               r_hit_sky;
    logic               r_hit_gnd;
    logic               r_overlap_x;
    logic               r_out_gap;
    logic               r_pass;
    logic               r_new_pipe;
    logic               r_passed;
    logic [CW-1:0]      r_dead_cnt;

    logic               w_start;
    logic               w_collision;
    logic               w_passed_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [SCORE_W-1:0] w_score_nxt;
    logic               w_move_nxt;
    logic               w_dead_nxt;

    // One extra bit keeps the bottom/right edge sums from wrapping.
    logic [EW-1:0] w_bird_top, w_bird_bot, w_pipe_l, w_pipe_r, w_gap_top, w_gap_bot;

    assign w_bird_top = {1'b0, iBirdPos};
    assign w_bird_bot = w_bird_top + C_BW_M1;
    assign w_pipe_l   = {1'b0, iPipeX};
    assign w_pipe_r   = w_pipe_l + C_PW_M1;
    assign w_gap_top  = {1'b0, iGapTop};
    assign w_gap_bot  = w_gap_top + C_GAP_M1;

    assign w_start     = iBtnStart & ~r_btn_prev;
    assign w_collision = r_hit_sky | r_hit_gnd | (r_overlap_x & r_out_gap);
    assign oState      = r_state;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_btn_prev  <= 1'b0;
            r_tick_d    <= 1'b0;
            r_hit_sky   <= 1'b0;
            r_hit_gnd   <= 1'b0;
            r_overlap_x <= 1'b0;
            r_out_gap   <= 1'b0;
            r_pass      <= 1'b0;
            r_new_pipe  <= 1'b0;
        end else begin
            r_btn_prev <= iBtnStart;
            r_tick_d   <= iFrameTick;
            if (iFrameTick) begin
                r_hit_sky   <= (w_bird_top <= C_SKY);
                r_hit_gnd   <= (w_bird_bot >= C_GND);
                r_overlap_x <= (w_pipe_l <= C_BIRD_R) && (w_pipe_r >= C_BIRD_L);
                r_out_gap   <= (w_bird_top < w_gap_top) || (w_bird_bot > w_gap_bot);
                r_pass      <= (w_pipe_r < C_BIRD_L);
                r_new_pipe  <= (w_pipe_l > C_BIRD_R);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_score_nxt  = oScore;
        w_passed_nxt = r_passed;
        w_cnt_nxt    = r_dead_cnt;
        w_move_nxt   = 1'b0;
        w_dead_nxt   = 1'b0;

        if (r_tick_d && r_new_pipe) begin
            w_passed_nxt = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                    w_score_nxt = '0;
                end
            end
            S_RUN: begin
                // Collision outranks a pass seen on the same frame.
                if (r_tick_d) begin
                    if (w_collision) begin
                        w_state_nxt = S_DEAD;
                        w_cnt_nxt   = '0;
                    end else if (r_pass && !r_passed) begin
                        w_passed_nxt = 1'b1;
                        if (oScore != C_SCORE_MAX) begin
                            w_score_nxt = oScore + 1'b1;
                        end
                    end
                end
            end
            S_DEAD: begin
                if (iFrameTick && (r_dead_cnt != C_DEAD_MAX)) begin
                    w_cnt_nxt = r_dead_cnt + 1'b1;
                end
                if (w_start && (r_dead_cnt == C_DEAD_MAX)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        case (w_state_nxt)
            S_RUN:   w_move_nxt = 1'b1;
            S_DEAD:  w_dead_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_state    <= S_IDLE;
            oScore     <= '0;
            r_passed   <= 1'b0;
            r_dead_cnt <= '0;
            oBirdMove  <= 1'b0;
            oBirdDead  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            oScore     <= w_score_nxt;
            r_passed   <= w_passed_nxt;
            r_dead_cnt <= w_cnt_nxt;
            oBirdMove  <= w_move_nxt;
            oBirdDead  <= w_dead_nxt;
        end
    end

endmodule

// File: tb/tb_game_status.sv
// tb/tb_game_status.sv - directed self-checking bench for game_status
`timescale 1ns/1ps

module tb_game_status;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       btn;
    logic [9:0] bird_pos;
    logic [9:0] pipe_x;
    logic [9:0] gap_top;
    logic       move;
    logic       dead;
    logic [7:0] score;
    logic [1:0] state;

    int n_total = 0;
    int n_bad   = 0;

    game_status dut (
        .iClk       (clk),
        .iRst       (rst),
        .iFrameTick (tick),
        .iBtnStart  (btn),
        .iBirdPos   (bird_pos),
        .iPipeX     (pipe_x),
        .iGapTop    (gap_top),
        .oBirdMove  (move),
        .oBirdDead  (dead),
        .oScore     (score),
        .oState     (state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_frame();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic press();
        @(negedge clk) btn = 1'b1;
        @(negedge clk) btn = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] prev_state;
        int         entries;

        rst      = 1'b0;
        tick     = 1'b0;
        btn      = 1'b0;
        bird_pos = 10'd200;
        pipe_x   = 10'd300;
        gap_top  = 10'd180;

        repeat (3) @(negedge clk);
        check_eq("rst_state", state, 2'b00);
        check_eq("rst_move",  move,  0);
        check_eq("rst_dead",  dead,  0);
        check_eq("rst_score", score, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_state", state, 2'b00);

        // held start button: one IDLE->RUN only
        btn        = 1'b1;
        entries    = 0;
        prev_state = state;
        repeat (50) begin
            @(negedge clk);
            if (prev_state == 2'b00 && state == 2'b01) entries++;
            prev_state = state;
        end
        btn = 1'b0;
        check_eq("start_once",  entries, 1);
        check_eq("start_state", state, 2'b01);
        check_eq("start_move",  move, 1);
        check_eq("start_dead",  dead, 0);
        check_eq("start_score", score, 0);

        // pipe pass, bird inside the gap
        for (int x = 150; x >= 66; x -= 7) begin
            pipe_x = 10'(x);
            do_frame();
        end
        check_eq("pass_before", score, 0);
        check_eq("pass_alive",  state, 2'b01);
        pipe_x = 10'd59;
        do_frame();
        check_eq("pass_first", score, 1);
        pipe_x = 10'd52;
        do_frame();
        check_eq("pass_hold", score, 1);
        pipe_x = 10'd300;
        do_frame();
        pipe_x = 10'd59;
        do_frame();
        check_eq("pass_second", score, 2);

        // ground boundary, then ground hit on a frame that also passes
        pipe_x   = 10'd300;
        bird_pos = 10'd419;
        do_frame();
        check_eq("gnd_419_alive", state, 2'b01);
        check_eq("gnd_419_dead",  dead, 0);
        bird_pos = 10'd420;
        pipe_x   = 10'd50;
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        check_eq("gnd_t1_dead",  dead, 0);
        check_eq("gnd_t1_state", state, 2'b01);
        @(negedge clk);
        check_eq("gnd_t2_dead",  dead, 1);
        check_eq("gnd_t2_state", state, 2'b10);
        check_eq("gnd_t2_move",  move, 0);
        check_eq("gnd_pass_lost", score, 2);

        // dead timeout and counter saturation
        pipe_x = 10'd300;
        repeat (119) do_frame();
        press();
        check_eq("dead_119_ignored", state, 2'b10);
        repeat (3) do_frame();
        press();
        check_eq("dead_exit_state", state, 2'b00);
        check_eq("dead_exit_score", score, 2);
        check_eq("dead_exit_dead",  dead, 0);
        check_eq("dead_exit_move",  move, 0);

        // score saturation
        bird_pos = 10'd200;
        press();
        check_eq("restart_score", score, 0);
        check_eq("restart_state", state, 2'b01);
        for (int i = 0; i < 255; i++) begin
            pipe_x = 10'd300;
            do_frame();
            pipe_x = 10'd59;
            do_frame();
        end
        check_eq("score_255", score, 255);
        pipe_x = 10'd300;
        do_frame();
        pipe_x = 10'd59;
        do_frame();
        check_eq("score_sat", score, 255);
        check_eq("sat_state", state, 2'b01);

        // asynchronous reset mid-RUN
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("async_state", state, 2'b00);
        check_eq("async_score", score, 0);
        check_eq("async_move",  move, 0);
        check_eq("async_dead",  dead, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_state", state, 2'b00);

        // pipe body hit outside the gap
        pipe_x = 10'd300;
        press();
        check_eq("run2_state", state, 2'b01);
        bird_pos = 10'd150;
        pipe_x   = 10'd100;
        do_frame();
        check_eq("pipe_hit_state", state, 2'b10);
        check_eq("pipe_hit_dead",  dead, 1);
        check_eq("pipe_hit_score", score, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
